// File: rtl/conc_trace_recorder_if.sv
// -----------------------------------------------------------------------------
// conc_trace_recorder_if
//   Record read-out port of the trace recorder: a valid/ready handshake
//   carrying {run_len, data} records from the recorder FIFO to the dumper.
//   Signals:
//     rd_valid  recorder -> dumper   head record available
//     rd_ready  dumper   -> recorder head record accepted this cycle
//     rd_data   recorder -> dumper   {run_len, data} at the FIFO head
//   Modports: master = recorder side, slave = dumper side.
// -----------------------------------------------------------------------------
interface conc_trace_recorder_if #(
   parameter int DATA_W = 6,
   parameter int RUN_W  = 10
);
   logic                    rd_valid;
   logic                    rd_ready;
   logic [RUN_W+DATA_W-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/conc_trace_recorder.sv
// -----------------------------------------------------------------------------
// conc_trace_recorder
//   Samples a DUT output vector every enabled cycle, compresses runs of
//   identical samples into {run_len, data} records and queues them in a
//   first-word fall-through FIFO that drains over a valid/ready port.
//   Ports:
//     clock     rising-edge clock
//     reset     asynchronous, active-low
//     enable    sample is valid this cycle
//     sample    DUT output vector (DATA_W)
//     flush     close the open run now
//     rd_if     record read-out port (master side): rd_valid/rd_ready/rd_data
//     count     number of queued records (0..DEPTH)
//     overflow  sticky: a record was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module conc_trace_recorder #(
   parameter int DATA_W = 6,
   parameter int RUN_W  = 10,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [DATA_W-1:0]         sample,
   input  logic                      flush,
   conc_trace_recorder_if.master     rd_if,
   output logic [ADDR_W:0]           count,
   output logic                      overflow
);

   localparam int REC_W = RUN_W + DATA_W;
   localparam logic [RUN_W-1:0]  RUN_MAX  = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  cur_q, cur_d;
   logic [RUN_W-1:0]   run_len_q, run_len_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic               overflow_q, overflow_d;

   logic [REC_W-1:0]   mem_q [DEPTH];

   logic               push;
   logic [REC_W-1:0]   push_rec;
   logic               pop;
   logic               full;
   logic               wr_en;

   // Run-length compressor: decides when the open run closes.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      run_len_d = run_len_q;
      push      = 1'b0;
      push_rec  = {run_len_q, cur_q};
      unique case (state_q)
         IDLE: begin
            // flush while idle has no open run to close, so nothing is pushed
            if (enable && !flush) begin
               cur_d     = sample;
               run_len_d = RUN_ONE;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (!enable || flush) begin
               // closing cycle: the sample on the bus is deliberately ignored
               push    = 1'b1;
               state_d = IDLE;
            end else if (sample == cur_q && run_len_q != RUN_MAX) begin
               run_len_d = run_len_q + RUN_ONE;
            end else begin
               // value change or saturated run: close it and start a fresh one
               push      = 1'b1;
               cur_d     = sample;
               run_len_d = RUN_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO bookkeeping. When full, a simultaneous pop frees the slot the push
   // lands in (wr_ptr == rd_ptr), so the push is still accepted.
   always_comb begin
      full       = (count_q == CNT_FULL);
      pop        = (count_q != '0) && rd_if.rd_ready;
      wr_en      = push && (!full || pop);
      overflow_d = overflow_q | (push && full && !pop);
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d    = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         run_len_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         run_len_q  <= run_len_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: stale entries are never visible while count==0.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_rec;
      end
   end

   assign rd_if.rd_valid = (count_q != '0);
   assign rd_if.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count          = count_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// -----------------------------------------------------------------------------
// tb_conc_trace_recorder
//   Directed bench for conc_trace_recorder: single run, value changes,
//   saturation, overflow, full with simultaneous pop/push, flush handling and
//   asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_conc_trace_recorder;

   localparam int DATA_W = 6;
   localparam int RUN_W  = 10;
   localparam int DEPTH  = 16;
   localparam int REC_W  = RUN_W + DATA_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic [DATA_W-1:0] sample;
   logic              flush;
   logic [4:0]        count;
   logic              overflow;

   int vectors    = 0;
   int miscompares = 0;

   conc_trace_recorder_if #(.DATA_W(DATA_W), .RUN_W(RUN_W)) rd_if ();

   conc_trace_recorder #(.DATA_W(DATA_W), .RUN_W(RUN_W), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .sample   (sample),
      .flush    (flush),
      .rd_if    (rd_if),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [REC_W-1:0] rec(input int len, input int data);
      return {RUN_W'(len), DATA_W'(data)};
   endfunction

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; sample = '0; flush = 1'b0; rd_if.rd_ready = 1'b0;
      step(); step();
      vectors++;
      if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || count !== 5'd0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b, want 0/0/0/0",
                  rd_if.rd_valid, rd_if.rd_data, count, overflow);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_single_run();
      enable = 1'b1; sample = 6'h0A;
      repeat (5) step();
      vectors++;
      if (count !== 5'd0) begin
         miscompares++;
         $display("FAIL t1_open_run_count: got %0d want 0", count);
      end
      enable = 1'b0;
      step();
      vectors++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== rec(5, 'h0A) || count !== 5'd1) begin
         miscompares++;
         $display("FAIL t1_record: valid=%b data=%h count=%0d, want 1/%h/1",
                  rd_if.rd_valid, rd_if.rd_data, count, rec(5, 'h0A));
      end
      // head must hold while not accepted
      step(); step();
      vectors++;
      if (rd_if.rd_data !== rec(5, 'h0A) || count !== 5'd1) begin
         miscompares++;
         $display("FAIL t1_hold: data=%h count=%0d, want %h/1", rd_if.rd_data, count, rec(5, 'h0A));
      end
      rd_if.rd_ready = 1'b1;
      step();
      rd_if.rd_ready = 1'b0;
      vectors++;
      if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== '0 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL t1_drained: valid=%b data=%h count=%0d, want 0/0/0",
                  rd_if.rd_valid, rd_if.rd_data, count);
      end
   endtask

   task automatic test_changes();
      logic [REC_W-1:0] exp [3];
      logic [DATA_W-1:0] seq [4];
      exp[0] = rec(1, 'h01); exp[1] = rec(2, 'h02); exp[2] = rec(1, 'h01);
      seq[0] = 6'h01; seq[1] = 6'h02; seq[2] = 6'h02; seq[3] = 6'h01;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample = seq[i];
         step();
      end
      enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd3) begin
         miscompares++;
         $display("FAIL t2_count: got %0d want 3", count);
      end
      rd_if.rd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp[k]) begin
            miscompares++;
            $display("FAIL t2_rec%0d: valid=%b data=%h, want 1/%h", k, rd_if.rd_valid, rd_if.rd_data, exp[k]);
         end
         step();
      end
      rd_if.rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd0) begin
         miscompares++;
         $display("FAIL t2_empty: count=%0d want 0", count);
      end
   endtask

   task automatic test_saturation();
      enable = 1'b1; sample = 6'h3F;
      repeat (1030) step();
      enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd2) begin
         miscompares++;
         $display("FAIL t3_count: got %0d want 2", count);
      end
      rd_if.rd_ready = 1'b1;
      vectors++;
      if (rd_if.rd_data !== rec(1023, 'h3F)) begin
         miscompares++;
         $display("FAIL t3_saturated: data=%h want %h", rd_if.rd_data, rec(1023, 'h3F));
      end
      step();
      vectors++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== rec(7, 'h3F)) begin
         miscompares++;
         $display("FAIL t3_tail: valid=%b data=%h, want 1/%h", rd_if.rd_valid, rd_if.rd_data, rec(7, 'h3F));
      end
      step();
      rd_if.rd_ready = 1'b0;
   endtask

   task automatic test_overflow();
      // samples 1..17 back to back, then close: 17 length-1 records
      enable = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         sample = DATA_W'(i);
         step();
      end
      enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL t4_full: count=%0d ovf=%b, want 16/1", count, overflow);
      end
      rd_if.rd_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         vectors++;
         if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== rec(1, k)) begin
            miscompares++;
            $display("FAIL t4_rec%0d: valid=%b data=%h, want 1/%h", k, rd_if.rd_valid, rd_if.rd_data, rec(1, k));
         end
         step();
      end
      rd_if.rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd0 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL t4_sticky: count=%0d ovf=%b, want 0/1", count, overflow);
      end
   endtask

   task automatic test_full_pop_push();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_ovf_cleared: got %b want 0", overflow);
      end
      enable = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         sample = DATA_W'(i);
         step();
      end
      enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_filled: count=%0d ovf=%b, want 16/0", count, overflow);
      end
      enable = 1'b1; sample = 6'h30;
      step();
      // close the run while popping the head
      enable = 1'b0; rd_if.rd_ready = 1'b1;
      step();
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_pop_push: count=%0d ovf=%b, want 16/0", count, overflow);
      end
      for (int k = 2; k <= 17; k++) begin
         logic [REC_W-1:0] want;
         want = (k == 17) ? rec(1, 'h30) : rec(1, k);
         vectors++;
         if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== want) begin
            miscompares++;
            $display("FAIL t5_rec%0d: valid=%b data=%h, want 1/%h", k, rd_if.rd_valid, rd_if.rd_data, want);
         end
         step();
      end
      rd_if.rd_ready = 1'b0;
      vectors++;
      if (count !== 5'd0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_end: count=%0d ovf=%b, want 0/0", count, overflow);
      end
   endtask

   task automatic test_flush();
      // flush while idle: nothing pushed, no run opened
      enable = 1'b1; flush = 1'b1; sample = 6'h2A;
      step();
      enable = 1'b0; flush = 1'b0;
      step();
      vectors++;
      if (count !== 5'd0 || rd_if.rd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_idle: count=%0d valid=%b, want 0/0", count, rd_if.rd_valid);
      end
      // flush closes an open run; the sample on the flush cycle is ignored
      enable = 1'b1; sample = 6'h22;
      repeat (3) step();
      flush = 1'b1; sample = 6'h01;
      step();
      flush = 1'b0; enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd1 || rd_if.rd_data !== rec(3, 'h22)) begin
         miscompares++;
         $display("FAIL flush_run: count=%0d data=%h, want 1/%h", count, rd_if.rd_data, rec(3, 'h22));
      end
      rd_if.rd_ready = 1'b1;
      step();
      rd_if.rd_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      enable = 1'b1;
      for (int i = 5; i <= 8; i++) begin
         sample = DATA_W'(i);
         step();
      end
      vectors++;
      if (count !== 5'd3) begin
         miscompares++;
         $display("FAIL t6_queued: count=%0d want 3", count);
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (rd_if.rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || rd_if.rd_data !== '0) begin
         miscompares++;
         $display("FAIL t6_async: valid=%b count=%0d ovf=%b data=%h, want 0/0/0/0",
                  rd_if.rd_valid, count, overflow, rd_if.rd_data);
      end
      enable = 1'b0;
      step();
      reset = 1'b1;
      step();
      vectors++;
      if (count !== 5'd0) begin
         miscompares++;
         $display("FAIL t6_no_stale_run: count=%0d want 0", count);
      end
      enable = 1'b1; sample = 6'h11;
      repeat (2) step();
      enable = 1'b0;
      step();
      vectors++;
      if (count !== 5'd1 || rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== rec(2, 'h11)) begin
         miscompares++;
         $display("FAIL t6_new_run: count=%0d valid=%b data=%h, want 1/1/%h",
                  count, rd_if.rd_valid, rd_if.rd_data, rec(2, 'h11));
      end
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_changes();
      test_saturation();
      test_overflow();
      test_full_pop_push();
      test_flush();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
